// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: result-source encoding and
// funct3 load-size codes.
package wb_pkg;

    typedef enum logic [2:0] {
        SRC_ALU = 3'b000,
        SRC_MEM = 3'b001,
        SRC_PC4 = 3'b010,
        SRC_IMM = 3'b011,
        SRC_CSR = 3'b100
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Sub-word load alignment: picks the byte/half addressed by offset and sign- or
// zero-extends it according to funct3. Used only when WB_LOAD_ALIGN_EN is defined.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword loads ignore offset[0]; misalignment is trapped upstream.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        aligned = rdata;
        case (funct3)
            F3_LB:   aligned = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  aligned = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   aligned = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  aligned = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   aligned = rdata;
            default: aligned = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: M/W pipeline register, result-source mux, regfile write port and
// retired-instruction counter. Define WB_LOAD_ALIGN_EN to align sub-word loads here.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallW,
    input  logic             FlushW,
    input  logic             ValidM,
    input  logic             RegWriteM,
    input  logic [2:0]       ResultSrcM,
    input  logic [2:0]       Funct3M,
    input  logic [XLEN-1:0]  AluResultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    input  logic [XLEN-1:0]  ImmExtM,
    input  logic [XLEN-1:0]  CsrRDataM,
    input  logic [4:0]       RdM,
    output logic             ValidW,
    output logic             RegWriteW,
    output logic [4:0]       RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic [CNT_W-1:0] InstRetW
);

    logic             valid_q, valid_d;
    logic             regwrite_q, regwrite_d;
    logic [2:0]       src_q, src_d;
    logic [XLEN-1:0]  alu_q, alu_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [XLEN-1:0]  pc4_q, pc4_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [XLEN-1:0]  csr_q, csr_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  mem_data;
    logic             load_en;

    // Flush beats stall; a flush only needs to kill valid/regwrite.
    assign load_en = !FlushW && !StallW;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        src_d      = src_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        pc4_d      = pc4_q;
        imm_d      = imm_q;
        csr_d      = csr_q;
        rd_d       = rd_q;
        if (FlushW) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (load_en) begin
            valid_d    = ValidM;
            regwrite_d = RegWriteM;
            src_d      = ResultSrcM;
            alu_d      = AluResultM;
            rdata_d    = ReadDataM;
            pc4_d      = PCPlus4M;
            imm_d      = ImmExtM;
            csr_d      = CsrRDataM;
            rd_d       = RdM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            src_q      <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            csr_q      <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            src_q      <= src_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            pc4_q      <= pc4_d;
            imm_q      <= imm_d;
            csr_q      <= csr_d;
            rd_q       <= rd_d;
        end
    end

    // An instruction retires when it leaves W, i.e. it is valid and not held.
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !StallW) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

`ifdef WB_LOAD_ALIGN_EN
    logic [2:0] funct3_q, funct3_d;

    always_comb begin
        funct3_d = funct3_q;
        if (load_en) begin
            funct3_d = Funct3M;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q <= '0;
        end else begin
            funct3_q <= funct3_d;
        end
    end

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata   (rdata_q),
        .offset  (alu_q[1:0]),
        .funct3  (funct3_q),
        .aligned (mem_data)
    );
`else
    // Load unit already delivers aligned data; funct3 is not needed here.
    logic unused_funct3;
    assign unused_funct3 = ^Funct3M;
    assign mem_data      = rdata_q;
`endif

    always_comb begin
        ResultW = '0;
        case (src_q)
            SRC_ALU: ResultW = alu_q;
            SRC_MEM: ResultW = mem_data;
            SRC_PC4: ResultW = pc4_q;
            SRC_IMM: ResultW = imm_q;
            SRC_CSR: ResultW = csr_q;
            default: ResultW = '0;
        endcase
    end

    assign ValidW    = valid_q;
    assign RegWriteW = regwrite_q && valid_q && (rd_q != 5'd0);
    assign RdW       = rd_q;
    assign InstRetW  = instret_q;

endmodule
